// File: rtl/prog_mem_loader.sv
// prog_mem_loader: framed byte-stream loader that fills program memory and holds the CPU until the image verifies
module prog_mem_loader #(
    parameter int                    BIT_WIDTH      = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 6,
    parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [1:0]            err_code
);
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [31:0] MAX_LEN = 32'((1 << ADDR_WIDTH) - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            idx_q, idx_d;
    logic [BIT_WIDTH-1:0]  word_q, word_d;
    logic [BYTE_WIDTH-1:0] csum_q, csum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [1:0]            err_q, err_d;

    logic accept, is_sync, counting, tmo_hit, len_ovf, last_word;

    assign accept    = in_valid && in_ready;
    assign is_sync   = in_data == SYNC_BYTE;
    assign counting  = state_q inside {S_LEN, S_DATA, S_CSUM};
    assign tmo_hit   = counting && !accept && ((tmo_q + 1'b1) == TMO_MAX);
    assign len_ovf   = 32'(in_data) > MAX_LEN;
    assign last_word = addr_q == len_q;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Next state: framing sequence, with inactivity timeout in the in-frame states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = (accept && is_sync) ? S_LEN : state_q;
            S_LEN:   state_d = accept ? (len_ovf ? S_ERR : S_DATA) : (tmo_hit ? S_ERR : state_q);
            S_DATA:  state_d = accept ? ((idx_q == 2'd3) ? S_WRITE : S_DATA) : (tmo_hit ? S_ERR : state_q);
            S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
            S_CSUM:  state_d = accept ? ((in_data == csum_q) ? S_DONE : S_ERR) : (tmo_hit ? S_ERR : state_q);
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, running checksum, address, timeout and error code
    always_comb begin
        len_d  = len_q;
        addr_d = addr_q;
        idx_d  = idx_q;
        word_d = word_q;
        csum_d = csum_q;
        err_d  = err_q;
        tmo_d  = (counting && !accept && !tmo_hit) ? tmo_q + 1'b1 : '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: err_d = (accept && is_sync) ? 2'd0 : err_q;
            S_LEN: begin
                if (accept) begin
                    len_d  = ADDR_WIDTH'(in_data);
                    csum_d = in_data;
                    addr_d = '0;
                    idx_d  = '0;
                    err_d  = len_ovf ? 2'd1 : err_q;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = {word_q[BIT_WIDTH-BYTE_WIDTH-1:0], in_data};
                    csum_d = csum_q ^ in_data;
                    idx_d  = idx_q + 1'b1;
                end
            end
            S_WRITE: addr_d = addr_q + 1'b1;
            S_CSUM:  err_d = (accept && in_data != csum_q) ? 2'd2 : err_q;
            default: ;
        endcase
        if (tmo_hit)
            err_d = 2'd3;
    end

    // Outputs decoded from state; the write stage blocks input for its single cycle
    always_comb begin
        in_ready  = rst && (state_q != S_WRITE);
        mem_wr_en = state_q == S_WRITE;
        mem_addr  = addr_q;
        mem_data  = word_q;
        cpu_hold  = state_q != S_DONE;
        done      = state_q == S_DONE;
        err_code  = err_q;
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: randomized and directed frame stimulus checked against a frame-level reference model
module tb_prog_mem_loader;
    localparam int AW = 6;
    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int fix_pos = -1;
    int fix_gap = 0;
    logic prev_wr = 1'b0;
    logic [31:0] shadow [0:(1<<AW)-1];
    logic [31:0] fr_words [$];

    prog_mem_loader #(
        .BIT_WIDTH(32),
        .BYTE_WIDTH(8),
        .ADDR_WIDTH(AW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory-side observer: shadow memory, write count, strobe shape, ready blocked only while writing
    always @(negedge clk) begin
        if (rst) begin
            if (mem_wr_en) begin
                wr_cnt++;
                shadow[mem_addr] = mem_data;
            end
            check("ready_vs_write", 64'(in_ready), 64'(!mem_wr_en));
            check("strobe_one_cycle", 64'(mem_wr_en && prev_wr), 64'(0));
            prev_wr = mem_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready)
            check("in_ready_wait", 64'(in_ready), 64'(1));
        else
            tick();
        in_valid = 1'b0;
    endtask

    function automatic int gap_for(input int idx, input int gmax);
        return (idx == fix_pos) ? fix_gap : int'($urandom_range(gmax, 0));
    endfunction

    function automatic logic [7:0] frame_csum(input logic [7:0] len);
        logic [7:0] c = len;
        foreach (fr_words[k]) c ^= fr_words[k][31:24] ^ fr_words[k][23:16] ^ fr_words[k][15:8] ^ fr_words[k][7:0];
        return c;
    endfunction

    function automatic logic [1:0] frame_err(input logic [7:0] len, input logic [7:0] csum);
        if (int'(len) >= (1 << AW)) return 2'd1;
        return (csum == frame_csum(len)) ? 2'd0 : 2'd2;
    endfunction

    task automatic send_frame(input logic [7:0] len, input logic [7:0] csum, input int gmax);
        int idx = 0;
        int w0;
        logic [1:0] e;
        logic [31:0] w;
        e = frame_err(len, csum);
        send(8'hA5, gap_for(idx++, gmax));
        check("sync_done", 64'(done), 64'(0));
        check("sync_hold", 64'(cpu_hold), 64'(1));
        check("sync_err", 64'(err_code), 64'(0));
        w0 = wr_cnt;
        send(len, gap_for(idx++, gmax));
        if (e == 2'd1) begin
            check("ovf_err", 64'(err_code), 64'(1));
            check("ovf_hold", 64'(cpu_hold), 64'(1));
            repeat (3) tick();
            check("ovf_no_write", 64'(wr_cnt), 64'(w0));
            return;
        end
        for (int k = 0; k <= int'(len); k++) begin
            w = fr_words[k];
            for (int b = 0; b < 4; b++) send(8'(w >> (24 - 8 * b)), gap_for(idx++, gmax));
            check("wr_strobe", 64'(mem_wr_en), 64'(1));
            check("wr_addr", 64'(mem_addr), 64'(k));
            check("wr_data", 64'(mem_data), 64'(w));
        end
        send(csum, gap_for(idx++, gmax));
        check("frame_err", 64'(err_code), 64'(e));
        check("frame_done", 64'(done), 64'(e == 2'd0));
        check("frame_hold", 64'(cpu_hold), 64'(e != 2'd0));
        check("frame_wr_count", 64'(wr_cnt - w0), 64'(int'(len) + 1));
    endtask

    initial begin
        int w0;
        logic [7:0] len, cs, jb;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) tick();
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_hold", 64'(cpu_hold), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err_code), 64'(0));
        check("rst_wr", 64'(mem_wr_en), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_data", 64'(mem_data), 64'(0));
        rst = 1'b1;
        #1;
        check("rel_ready", 64'(in_ready), 64'(1));
        tick();
        check("rel_hold", 64'(cpu_hold), 64'(1));

        // Directed good frame, in_valid continuously high
        fr_words = {32'h12345678, 32'h9ABCDEF0};
        w0 = wr_cnt;
        send_frame(8'h01, 8'h01, 0);
        check("good_mem0", 64'(shadow[0]), 64'h12345678);
        check("good_mem1", 64'(shadow[1]), 64'h9ABCDEF0);
        check("good_done", 64'(done), 64'(1));
        send(8'h00, 0);
        send(8'h5A, 1);
        check("done_discard", 64'(done), 64'(1));

        // Bad checksum, then a good frame clears the error
        send_frame(8'h01, 8'h00, 0);
        check("bad_err", 64'(err_code), 64'(2));
        fr_words = {32'hCAFEF00D, 32'h0BADBEEF, 32'hA5A5A5A5};
        send_frame(8'h02, frame_csum(8'h02), 1);
        check("recover_done", 64'(done), 64'(1));

        // Reload from DONE rewrites from address 0
        fr_words = {32'hA5000001};
        send_frame(8'h00, frame_csum(8'h00), 2);
        check("reload_mem0", 64'(shadow[0]), 64'hA5000001);

        // Length overflow, then junk is ignored in ERR
        send_frame(8'h40, 8'h00, 0);
        send(8'h11, 0);
        check("err_discard", 64'(err_code), 64'(1));

        // Timeout boundary: 15 idle cycles keep waiting, the 16th errors out
        w0 = wr_cnt;
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        repeat (TMO - 1) tick();
        check("tmo_not_yet", 64'(err_code), 64'(0));
        tick();
        check("tmo_err", 64'(err_code), 64'(3));
        check("tmo_hold", 64'(cpu_hold), 64'(1));
        check("tmo_no_write", 64'(wr_cnt), 64'(w0));

        // 15-cycle gap inside a word is tolerated
        fr_words = {32'h12345678, 32'h9ABCDEF0};
        fix_pos = 3;
        fix_gap = TMO - 1;
        send_frame(8'h01, 8'h01, 0);
        fix_pos = -1;
        check("gap15_done", 64'(done), 64'(1));

        // Reset during the second word
        fr_words = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        send(8'hA5, 0);
        send(8'h03, 0);
        for (int b = 0; b < 4; b++) send(8'(32'h01020304 >> (24 - 8 * b)), 0);
        send(8'h05, 0);
        send(8'h06, 0);
        w0 = wr_cnt;
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        check("mid_rst_hold", 64'(cpu_hold), 64'(1));
        check("mid_rst_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        rst = 1'b1;
        #1;
        check("mid_rel_ready", 64'(in_ready), 64'(1));
        send(8'h07, 0);
        send(8'h08, 0);
        repeat (2) tick();
        check("mid_no_write", 64'(wr_cnt), 64'(w0));
        check("mid_keep_mem0", 64'(shadow[0]), 64'h01020304);
        check("mid_idle_hold", 64'(cpu_hold), 64'(1));
        check("mid_idle_err", 64'(err_code), 64'(0));

        // Random frames against the model
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(2, 0)) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h00;
                send(jb, int'($urandom_range(2, 0)));
            end
            fr_words.delete();
            if ($urandom_range(7, 0) == 0) begin
                len = 8'($urandom_range(255, 1 << AW));
            end else begin
                len = ($urandom_range(5, 0) == 0) ? 8'($urandom_range((1 << AW) - 1, 0)) : 8'($urandom_range(7, 0));
                for (int k = 0; k <= int'(len); k++) fr_words.push_back($urandom);
            end
            cs = frame_csum(len);
            if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
            send_frame(len, cs, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
